// File: rtl/sysid_pkg.sv
// Shared word map, CTRL/CAPS field positions and data width for the sysid register file.
package sysid_pkg;

  localparam int unsigned SYSID_DATA_W = 32;

  typedef enum logic [2:0] {
    SYSID_W_ID        = 3'd0,
    SYSID_W_TIMESTAMP = 3'd1,
    SYSID_W_VERSION   = 3'd2,
    SYSID_W_SCRATCH   = 3'd3,
    SYSID_W_UPTIME_LO = 3'd4,
    SYSID_W_UPTIME_HI = 3'd5,
    SYSID_W_CAPS      = 3'd6,
    SYSID_W_CTRL      = 3'd7
  } sysid_word_e;

  localparam int unsigned SYSID_CTRL_CLR      = 0;
  localparam int unsigned SYSID_CTRL_FREEZE   = 1;

  localparam int unsigned SYSID_CAPS_UPTIME   = 0;
  localparam int unsigned SYSID_CAPS_CNTW_LSB = 8;
  localparam int unsigned SYSID_CAPS_FREEZE   = 16;

endpackage

// File: rtl/sysid_regfile_avmm_if.sv
// Avalon-MM slave bus bundle for the sysid register file (no waitrequest, read latency 1).
interface sysid_regfile_avmm_if #(
  parameter int unsigned ADDR_W = 3
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with freeze, synchronous clear (clear wins) and
// a high-word snapshot taken on LO reads so LO-then-HI sequences stay coherent.
module sysid_uptime_ctr #(
  parameter int unsigned CNT_W = 48
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             freeze,
  input  logic             snap,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      snap_hi
);

  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-33:0] r_snap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (!freeze) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_snap <= '0;
    end else if (snap) begin
      r_snap <= r_count[CNT_W-1:32];
    end
  end

  assign count   = r_count;
  assign snap_hi = 32'(r_snap);

endmodule

// File: rtl/sysid_regfile_avmm.sv
// System-ID register file on Avalon-MM: constants, byte-writable scratch, read mux.
// Uptime counter, snapshot and CTRL are built only when SYSID_UPTIME_EN is defined.
module sysid_regfile_avmm
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0] SYSID_TIMESTAMP = 32'h58D7_29D7,
  parameter logic [31:0] SYSID_VERSION   = 32'h0001_0000,
  parameter int unsigned CNT_W           = 48,
  parameter int unsigned ADDR_W          = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sysid_regfile_avmm_if.slave  avs
);

  if (CNT_W < 33 || CNT_W > 64) begin : g_cnt_w_check
    $error("sysid_regfile_avmm: CNT_W must be within 33..64");
  end

  logic [31:0] r_scratch;
  logic [31:0] r_readdata;
  logic        r_readdatavalid;
  logic [31:0] w_rdmux;
  logic [31:0] w_uptime_lo;
  logic [31:0] w_uptime_hi;
  logic [31:0] w_caps;
  logic [31:0] w_ctrl_rd;
  logic        w_wr_scratch;

  assign w_wr_scratch = avs.write && (avs.address == ADDR_W'(SYSID_W_SCRATCH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scratch <= '0;
    end else if (w_wr_scratch) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (avs.byteenable[b]) r_scratch[8*b +: 8] <= avs.writedata[8*b +: 8];
      end
    end
  end

`ifdef SYSID_UPTIME_EN
  logic             r_freeze;
  logic             w_wr_ctrl;
  logic             w_clr;
  logic             w_snap;
  logic [CNT_W-1:0] w_count;

  assign w_wr_ctrl = avs.write && (avs.address == ADDR_W'(SYSID_W_CTRL));
  assign w_clr     = w_wr_ctrl && avs.writedata[SYSID_CTRL_CLR];
  assign w_snap    = avs.read && (avs.address == ADDR_W'(SYSID_W_UPTIME_LO));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_freeze <= 1'b0;
    end else if (w_wr_ctrl) begin
      r_freeze <= avs.writedata[SYSID_CTRL_FREEZE];
    end
  end

  sysid_uptime_ctr #(.CNT_W(CNT_W)) u_uptime (
    .clock   (clock),
    .reset_n (reset_n),
    .clr     (w_clr),
    .freeze  (r_freeze),
    .snap    (w_snap),
    .count   (w_count),
    .snap_hi (w_uptime_hi)
  );

  assign w_uptime_lo = w_count[31:0];

  always_comb begin
    w_caps                                  = '0;
    w_caps[SYSID_CAPS_UPTIME]               = 1'b1;
    w_caps[SYSID_CAPS_CNTW_LSB +: 8]        = 8'(CNT_W);
    w_caps[SYSID_CAPS_FREEZE]               = r_freeze;
    w_ctrl_rd                               = '0;
    w_ctrl_rd[SYSID_CTRL_FREEZE]            = r_freeze;
  end
`else
  assign w_uptime_lo = '0;
  assign w_uptime_hi = '0;
  assign w_caps      = '0;
  assign w_ctrl_rd   = '0;
`endif

  always_comb begin
    w_rdmux = '0;
    case (avs.address)
      ADDR_W'(SYSID_W_ID):        w_rdmux = SYSID_ID;
      ADDR_W'(SYSID_W_TIMESTAMP): w_rdmux = SYSID_TIMESTAMP;
      ADDR_W'(SYSID_W_VERSION):   w_rdmux = SYSID_VERSION;
      ADDR_W'(SYSID_W_SCRATCH):   w_rdmux = r_scratch;
      ADDR_W'(SYSID_W_UPTIME_LO): w_rdmux = w_uptime_lo;
      ADDR_W'(SYSID_W_UPTIME_HI): w_rdmux = w_uptime_hi;
      ADDR_W'(SYSID_W_CAPS):      w_rdmux = w_caps;
      ADDR_W'(SYSID_W_CTRL):      w_rdmux = w_ctrl_rd;
      default:                    w_rdmux = '0;
    endcase
  end

  // Mux samples pre-edge state, so a read colliding with a write returns the old value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata      <= '0;
      r_readdatavalid <= 1'b0;
    end else begin
      r_readdatavalid <= avs.read;
      if (avs.read) r_readdata <= w_rdmux;
    end
  end

  assign avs.readdata      = r_readdata;
  assign avs.readdatavalid = r_readdatavalid;

endmodule

// File: tb/tb_sysid_regfile_avmm.sv
// Directed, table-driven bench for sysid_regfile_avmm (adapts to SYSID_UPTIME_EN).
module tb_sysid_regfile_avmm;

  typedef struct {
    bit          wr;
    logic [2:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    logic [3:0]  be;
    string       name;
  } vec_t;

`ifdef SYSID_UPTIME_EN
  localparam logic [31:0] CAPS_EXP = 32'h0000_3001;
  localparam bit          UPTIME   = 1'b1;
`else
  localparam logic [31:0] CAPS_EXP = 32'h0000_0000;
  localparam bit          UPTIME   = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  vec_t        vecs[$];

  sysid_regfile_avmm_if #(.ADDR_W(3)) bus ();

  sysid_regfile_avmm #(
    .SYSID_ID        (32'h0000_0000),
    .SYSID_TIMESTAMP (32'h58D7_29D7),
    .SYSID_VERSION   (32'h0001_0000),
    .CNT_W           (48),
    .ADDR_W          (3)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .avs     (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit w, logic [2:0] a, logic [31:0] d, logic [3:0] be, string n);
    vec_t v;
    v.wr = w; v.addr = a; v.data = d; v.be = be; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capturing posedge.
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    bus.address = a;
    bus.read    = 1'b1;
    @(negedge clk);
    bus.read    = 1'b0;
    check({name, " valid"}, 32'(bus.readdatavalid), 32'd1);
    check(name, bus.readdata, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
    bus.write      = 1'b1;
    @(negedge clk);
    bus.write      = 1'b0;
  endtask

  initial begin
    logic [31:0] exp8 [8];

    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;

    vecs.push_back(mk(0, 3'd0, 32'h0000_0000, 4'h0, "id"));
    vecs.push_back(mk(0, 3'd1, 32'h58D7_29D7, 4'h0, "timestamp"));
    vecs.push_back(mk(0, 3'd2, 32'h0001_0000, 4'h0, "version"));
    vecs.push_back(mk(0, 3'd3, 32'h0000_0000, 4'h0, "scratch reset"));
    vecs.push_back(mk(0, 3'd6, CAPS_EXP,      4'h0, "caps"));
    vecs.push_back(mk(0, 3'd7, 32'h0000_0000, 4'h0, "ctrl reset"));
    vecs.push_back(mk(1, 3'd3, 32'hDEAD_BEEF, 4'b0101, "wr scratch be0101"));
    vecs.push_back(mk(0, 3'd3, 32'h00AD_00EF, 4'h0, "scratch be0101"));
    vecs.push_back(mk(1, 3'd3, 32'h1234_5678, 4'b1010, "wr scratch be1010"));
    vecs.push_back(mk(0, 3'd3, 32'h12AD_56EF, 4'h0, "scratch be1010"));
    vecs.push_back(mk(1, 3'd3, 32'hFFFF_FFFF, 4'b0000, "wr scratch be0000"));
    vecs.push_back(mk(0, 3'd3, 32'h12AD_56EF, 4'h0, "scratch be0000"));
    vecs.push_back(mk(1, 3'd1, 32'hFFFF_FFFF, 4'hF, "wr timestamp"));
    vecs.push_back(mk(0, 3'd1, 32'h58D7_29D7, 4'h0, "timestamp ro"));
    vecs.push_back(mk(1, 3'd0, 32'hFFFF_FFFF, 4'hF, "wr id"));
    vecs.push_back(mk(0, 3'd0, 32'h0000_0000, 4'h0, "id ro"));
    vecs.push_back(mk(1, 3'd2, 32'hFFFF_FFFF, 4'hF, "wr version"));
    vecs.push_back(mk(0, 3'd2, 32'h0001_0000, 4'h0, "version ro"));
`ifndef SYSID_UPTIME_EN
    vecs.push_back(mk(0, 3'd4, 32'h0000_0000, 4'h0, "uptime lo absent"));
    vecs.push_back(mk(0, 3'd5, 32'h0000_0000, 4'h0, "uptime hi absent"));
    vecs.push_back(mk(1, 3'd7, 32'h0000_0003, 4'hF, "wr ctrl absent"));
    vecs.push_back(mk(0, 3'd7, 32'h0000_0000, 4'h0, "ctrl absent"));
    vecs.push_back(mk(0, 3'd6, 32'h0000_0000, 4'h0, "caps after ctrl wr"));
`endif
    vecs.push_back(mk(1, 3'd3, 32'hCAFE_F00D, 4'hF, "wr scratch full"));
    vecs.push_back(mk(0, 3'd3, 32'hCAFE_F00D, 4'h0, "scratch full"));

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("reset readdata", bus.readdata, 32'h0);
    check("reset valid", 32'(bus.readdatavalid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle valid", 32'(bus.readdatavalid), 32'd0);

    foreach (vecs[i]) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      else            rd(vecs[i].addr, vecs[i].data, vecs[i].name);
    end

    // Pulse is one cycle wide and readdata holds afterwards
    @(negedge clk);
    check("valid pulse width", 32'(bus.readdatavalid), 32'd0);
    check("readdata hold", bus.readdata, 32'hCAFE_F00D);

    // Simultaneous read and write: write lands, read returns old value
    bus.address = 3'd3; bus.writedata = 32'h1111_1111; bus.byteenable = 4'hF;
    bus.read = 1'b1; bus.write = 1'b1;
    @(negedge clk);
    bus.read = 1'b0; bus.write = 1'b0;
    check("rw collide valid", 32'(bus.readdatavalid), 32'd1);
    check("rw collide data", bus.readdata, 32'hCAFE_F00D);
    rd(3'd3, 32'h1111_1111, "rw collide after");

    // Back-to-back reads of all eight words
    exp8 = '{32'h0000_0000, 32'h58D7_29D7, 32'h0001_0000, 32'h1111_1111,
             32'h0000_0000, 32'h0000_0000, CAPS_EXP, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      bus.address = 3'(i);
      bus.read    = 1'b1;
      @(negedge clk);
      check($sformatf("b2b valid %0d", i), 32'(bus.readdatavalid), 32'd1);
      if (!(UPTIME && i == 4)) check($sformatf("b2b data %0d", i), bus.readdata, exp8[i]);
    end
    bus.read = 1'b0;
    @(negedge clk);
    check("b2b end valid", 32'(bus.readdatavalid), 32'd0);

`ifdef SYSID_UPTIME_EN
    // Clear while freezing: counter parks at 0
    wr(3'd7, 32'h0000_0003, 4'hF);
    rd(3'd4, 32'h0000_0000, "frozen lo a");
    rd(3'd4, 32'h0000_0000, "frozen lo b");
    rd(3'd6, 32'h0001_3001, "caps frozen");
    rd(3'd7, 32'h0000_0002, "ctrl frozen");
    // Clear and unfreeze: 0 on the first read, then counting resumes
    wr(3'd7, 32'h0000_0001, 4'hF);
    rd(3'd4, 32'h0000_0000, "unfrozen lo a");
    rd(3'd4, 32'h0000_0001, "unfrozen lo b");
    rd(3'd7, 32'h0000_0000, "ctrl unfrozen");
    // Preload just below the 32-bit carry and check snapshot coherency
    force dut.u_uptime.r_count = 48'h0000_FFFF_FFFE;
    #1;
    release dut.u_uptime.r_count;
    rd(3'd4, 32'hFFFF_FFFE, "carry lo");
    repeat (3) @(negedge clk);
    rd(3'd5, 32'h0000_0000, "carry hi snapshot");
    rd(3'd4, 32'h0000_0003, "post carry lo");
    rd(3'd5, 32'h0000_0001, "post carry hi");
`endif

    // Reset asserted while a read response is out
    bus.address = 3'd1;
    bus.read    = 1'b1;
    @(posedge clk);
    #2;
    bus.read = 1'b0;
    check("pre-reset valid", 32'(bus.readdatavalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-read reset valid", 32'(bus.readdatavalid), 32'd0);
    check("mid-read reset data", bus.readdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(3'd3, 32'h0000_0000, "scratch after reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
